mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM/IO port of the CPU and shares it between instruction fetch and the load/store unit (LSU).
- Multi-byte requests are serialized into one-byte bus cycles, little-endian. Read data is reassembled; write data is split.
- Honours the global `ready` stall and the IO buffer-full backpressure.
- Sits between the core's fetch/LSU front-ends and the top-level memory pins.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide memory port sequencer shared by instruction fetch and the LSU.
// Multi-byte requests become little-endian single-byte bus cycles; reads are reassembled.
module mem_arbiter #(
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] IO_ADDR_MIN = 32'h0003_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  io_ifetch_req_valid,
    output logic                  io_ifetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] io_ifetch_addr,
    output logic                  io_ifetch_resp_valid,
    output logic [31:0]           io_ifetch_resp_data,
    input  logic                  io_lsu_req_valid,
    output logic                  io_lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] io_lsu_addr,
    input  logic                  io_lsu_write,
    input  logic [1:0]            io_lsu_size,
    input  logic [31:0]           io_lsu_wdata,
    output logic                  io_lsu_resp_valid,
    output logic [31:0]           io_lsu_resp_data,
    output logic [ADDR_WIDTH-1:0] io_mem_a,
    output logic                  io_mem_wr,
    output logic [7:0]            io_mem_dout,
    input  logic [7:0]            io_mem_din,
    input  logic                  io_io_buffer_full,
    output logic                  io_busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] IO_MIN = ADDR_WIDTH'(IO_ADDR_MIN);

    state_t                state_reg;
    logic [2:0]            cnt_reg;
    logic [2:0]            n_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ADDR_WIDTH-1:0] addr_hold_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           rdata_reg;
    logic [31:0]           rdata_next;
    logic [31:0]           ifetch_data_reg;
    logic [31:0]           lsu_data_reg;
    logic                  owner_lsu_reg;
    logic                  last_grant_lsu_reg;
    logic                  pending_reg;

    logic                  any_req;
    logic                  grant_lsu;
    logic                  accept;
    logic                  in_xfer;
    logic                  issuing;
    logic                  io_blocked;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [2:0]            lsu_len;

    always_comb begin
        lsu_len = 3'd4;
        case (io_lsu_size)
            2'd0:    lsu_len = 3'd1;
            2'd1:    lsu_len = 3'd2;
            default: lsu_len = 3'd4;
        endcase
    end

    // Round-robin: with both requesting, the side that did not win last time goes next.
    assign any_req   = io_ifetch_req_valid || io_lsu_req_valid;
    assign grant_lsu = io_lsu_req_valid && (!io_ifetch_req_valid || !last_grant_lsu_reg);
    assign accept    = !reset && (state_reg == IDLE) && ready && any_req;

    assign io_ifetch_req_ready = accept && !grant_lsu;
    assign io_lsu_req_ready    = accept && grant_lsu;

    assign cur_addr   = base_reg + ADDR_WIDTH'(cnt_reg);
    assign in_xfer    = (state_reg == READ) || (state_reg == WRITE);
    assign issuing    = ready && in_xfer && (cnt_reg < n_reg);
    assign io_blocked = (state_reg == WRITE) && (cur_addr >= IO_MIN) && io_io_buffer_full;

    // The address lingers on the bus whenever no new cycle is issued.
    assign io_mem_a    = issuing ? cur_addr : addr_hold_reg;
    assign io_mem_wr   = issuing && (state_reg == WRITE) && !io_blocked;
    assign io_mem_dout = io_mem_wr ? wdata_reg[{cnt_reg[1:0], 3'b000} +: 8] : 8'h00;

    assign io_ifetch_resp_valid = (state_reg == RESP) && ready && !owner_lsu_reg;
    assign io_lsu_resp_valid    = (state_reg == RESP) && ready && owner_lsu_reg;
    assign io_ifetch_resp_data  = ifetch_data_reg;
    assign io_lsu_resp_data     = lsu_data_reg;
    assign io_busy              = (state_reg != IDLE);

    // Byte returned this cycle belongs to the address issued one cycle earlier (slot cnt-1).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_capture
            assign rdata_next[gi*8 +: 8] = (pending_reg && (cnt_reg == 3'(gi + 1)))
                                         ? io_mem_din : rdata_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            cnt_reg            <= 3'd0;
            n_reg              <= 3'd0;
            base_reg           <= '0;
            addr_hold_reg      <= '0;
            wdata_reg          <= 32'h0;
            rdata_reg          <= 32'h0;
            ifetch_data_reg    <= 32'h0;
            lsu_data_reg       <= 32'h0;
            owner_lsu_reg      <= 1'b0;
            last_grant_lsu_reg <= 1'b1;
            pending_reg        <= 1'b0;
        end else begin
            addr_hold_reg <= io_mem_a;
            pending_reg   <= issuing && (state_reg == READ);
            rdata_reg     <= rdata_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        base_reg           <= grant_lsu ? io_lsu_addr : io_ifetch_addr;
                        n_reg              <= grant_lsu ? lsu_len : 3'd4;
                        wdata_reg          <= io_lsu_wdata;
                        owner_lsu_reg      <= grant_lsu;
                        last_grant_lsu_reg <= grant_lsu;
                        cnt_reg            <= 3'd0;
                        rdata_reg          <= 32'h0;
                        state_reg          <= (grant_lsu && io_lsu_write) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (issuing) begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end else if (ready && (cnt_reg == n_reg)) begin
                        state_reg <= RESP;
                        if (owner_lsu_reg) begin
                            lsu_data_reg <= rdata_next;
                        end else begin
                            ifetch_data_reg <= rdata_next;
                        end
                    end
                end
                WRITE: begin
                    if (issuing && !io_blocked) begin
                        cnt_reg <= cnt_reg + 3'd1;
                        if (cnt_reg == n_reg - 3'd1) begin
                            state_reg    <= RESP;
                            lsu_data_reg <= 32'h0;
                        end
                    end
                end
                RESP: begin
                    if (ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized traffic checked
// by a scoreboard against a shadow-memory reference model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic        f_valid, l_valid, l_write, buf_full;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic [1:0]  l_size;
    logic [7:0]  din;

    logic        io_ifetch_req_ready, io_ifetch_resp_valid;
    logic [31:0] io_ifetch_resp_data;
    logic        io_lsu_req_ready, io_lsu_resp_valid;
    logic [31:0] io_lsu_resp_data;
    logic [31:0] io_mem_a;
    logic        io_mem_wr;
    logic [7:0]  io_mem_dout;
    logic        io_busy;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(32), .IO_ADDR_MIN(32'h0003_0000)) dut (
        .clock                (clock),
        .reset                (reset),
        .ready                (ready),
        .io_ifetch_req_valid  (f_valid),
        .io_ifetch_req_ready  (io_ifetch_req_ready),
        .io_ifetch_addr       (f_addr),
        .io_ifetch_resp_valid (io_ifetch_resp_valid),
        .io_ifetch_resp_data  (io_ifetch_resp_data),
        .io_lsu_req_valid     (l_valid),
        .io_lsu_req_ready     (io_lsu_req_ready),
        .io_lsu_addr          (l_addr),
        .io_lsu_write         (l_write),
        .io_lsu_size          (l_size),
        .io_lsu_wdata         (l_wdata),
        .io_lsu_resp_valid    (io_lsu_resp_valid),
        .io_lsu_resp_data     (io_lsu_resp_data),
        .io_mem_a             (io_mem_a),
        .io_mem_wr            (io_mem_wr),
        .io_mem_dout          (io_mem_dout),
        .io_mem_din           (din),
        .io_io_buffer_full    (buf_full),
        .io_busy              (io_busy)
    );

    typedef struct {
        bit          store;
        logic [31:0] addr;
        int          n;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    exp_t        fq[$];
    exp_t        lq[$];
    bit          grant_log[$];
    logic [7:0]  shadow_mem[logic [31:0]];
    logic [7:0]  bus_mem[logic [31:0]];
    bit          model_last_lsu = 1'b1;
    bit          in_flight = 1'b0;
    bit          rand_done = 1'b0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] shadow_rd(logic [31:0] a);
        return shadow_mem.exists(a) ? shadow_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    // Little-endian read of n bytes from the reference memory, zero-extended.
    function automatic logic [31:0] model_read(logic [31:0] a, int n);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = shadow_rd(a + 32'(i));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %08h required %08h", name, got, exp);
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: no handshake within the cycle budget, required one", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory on the pins: one-cycle read latency, writes land when io_mem_wr is seen.
    initial begin : bus_model
        logic [31:0] a_s;
        din = 8'h00;
        forever begin
            @(negedge clock);
            a_s = io_mem_a;
            if (io_mem_wr) bus_mem[io_mem_a] = io_mem_dout;
            @(posedge clock);
            #1;
            din = bus_rd(a_s);
        end
    end

    // Scoreboard monitor: predicts grants at handshake, pushes expectations, pops on responses.
    always @(negedge clock) begin : monitor
        exp_t e;
        bit   exp_lsu;
        if (reset) begin
            fq.delete();
            lq.delete();
            model_last_lsu = 1'b1;
            in_flight = 1'b0;
        end else begin
            if (in_flight) chk("busy", 32'(io_busy), 32'd1);
            if (!ready) begin
                chk("stall_wr", 32'(io_mem_wr), 32'd0);
                chk("stall_req", 32'(io_ifetch_req_ready | io_lsu_req_ready), 32'd0);
                chk("stall_resp", 32'(io_ifetch_resp_valid | io_lsu_resp_valid), 32'd0);
            end
            if (io_ifetch_resp_valid) begin
                in_flight = 1'b0;
                if (fq.size() == 0) chk("ifetch_unexpected_resp", 32'(io_ifetch_resp_valid), 32'd0);
                else begin
                    e = fq.pop_front();
                    chk("ifetch_data", io_ifetch_resp_data, e.data);
                    $display("ifetch resp addr=%08h data=%08h", e.addr, io_ifetch_resp_data);
                end
            end
            if (io_lsu_resp_valid) begin
                in_flight = 1'b0;
                if (lq.size() == 0) chk("lsu_unexpected_resp", 32'(io_lsu_resp_valid), 32'd0);
                else begin
                    e = lq.pop_front();
                    chk("lsu_data", io_lsu_resp_data, e.data);
                    if (e.store)
                        for (int i = 0; i < e.n; i++) shadow_mem[e.addr + 32'(i)] = e.wdata[8*i +: 8];
                    $display("lsu %s resp addr=%08h n=%0d data=%08h", e.store ? "store" : "load",
                             e.addr, e.n, io_lsu_resp_data);
                end
            end
            if (io_ifetch_req_ready || io_lsu_req_ready) begin
                exp_lsu = l_valid && (!f_valid || !model_last_lsu);
                chk("grant_lsu", 32'(io_lsu_req_ready), 32'(exp_lsu));
                chk("both_ready", 32'(io_ifetch_req_ready & io_lsu_req_ready), 32'd0);
                chk("ready_without_valid",
                    32'((io_ifetch_req_ready & ~f_valid) | (io_lsu_req_ready & ~l_valid)), 32'd0);
                if (io_lsu_req_ready) begin
                    e.addr  = l_addr;
                    e.n     = (l_size == 2'd0) ? 1 : (l_size == 2'd1) ? 2 : 4;
                    e.store = l_write;
                    e.wdata = l_wdata;
                    e.data  = l_write ? 32'h0 : model_read(l_addr, e.n);
                    lq.push_back(e);
                end else begin
                    e.addr  = f_addr;
                    e.n     = 4;
                    e.store = 1'b0;
                    e.wdata = 32'h0;
                    e.data  = model_read(f_addr, 4);
                    fq.push_back(e);
                end
                model_last_lsu = io_lsu_req_ready;
                grant_log.push_back(io_lsu_req_ready);
                in_flight = 1'b1;
            end
        end
    end

    task automatic wait_accept(input bit lsu);
        int w;
        w = 0;
        forever begin
            @(negedge clock);
            if (lsu ? io_lsu_req_ready : io_ifetch_req_ready) break;
            w++;
            if (w > 2000) begin
                timeout_fail(lsu ? "lsu_accept" : "ifetch_accept");
                break;
            end
        end
    endtask

    // Latency in cycles from the accept cycle to the response pulse.
    task automatic wait_resp(input bit lsu, output int lat);
        lat = 0;
        forever begin
            tick();
            if (lat == 0) begin
                f_valid = 1'b0;
                l_valid = 1'b0;
            end
            lat++;
            @(negedge clock);
            if (lsu ? io_lsu_resp_valid : io_ifetch_resp_valid) break;
            if (lat > 60) begin
                timeout_fail("resp_wait");
                break;
            end
        end
        tick();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((fq.size() + lq.size()) != 0 && k < 3000) begin
            tick();
            k++;
        end
        chk("drain_outstanding", 32'(fq.size() + lq.size()), 32'd0);
    endtask

    task automatic rand_fetch(input int num);
        for (int i = 0; i < num; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            tick();
            f_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                  : 32'h0000_1000 + $urandom_range(0, 63);
            f_valid = 1'b1;
            wait_accept(1'b0);
            tick();
            f_valid = 1'b0;
        end
    endtask

    task automatic rand_lsu(input int num);
        for (int i = 0; i < num; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            tick();
            l_write = 1'($urandom_range(0, 1));
            l_size  = 2'($urandom_range(0, 3));
            l_addr  = ($urandom_range(0, 3) == 0) ? 32'h0003_0000 + $urandom_range(0, 15)
                                                  : 32'h0000_1000 + $urandom_range(0, 63);
            l_wdata = $urandom();
            l_valid = 1'b1;
            wait_accept(1'b1);
            tick();
            l_valid = 1'b0;
        end
    endtask

    initial begin : stimulus
        int          lat;
        int          k;
        logic [31:0] wd;
        logic [31:0] exp5;

        reset = 1'b1; ready = 1'b1; buf_full = 1'b0;
        f_valid = 1'b0; l_valid = 1'b0; l_write = 1'b0; l_size = 2'd0;
        f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;
        shadow_mem[32'h100] = 8'h13; shadow_mem[32'h101] = 8'h05;
        shadow_mem[32'h102] = 8'h10; shadow_mem[32'h103] = 8'h00;
        bus_mem[32'h100] = 8'h13; bus_mem[32'h101] = 8'h05;
        bus_mem[32'h102] = 8'h10; bus_mem[32'h103] = 8'h00;
        repeat (3) tick();
        @(negedge clock);
        chk("rst_busy", 32'(io_busy), 32'd0);
        chk("rst_mem_wr", 32'(io_mem_wr), 32'd0);
        chk("rst_mem_a", io_mem_a, 32'h0);
        chk("rst_dout", 32'(io_mem_dout), 32'd0);
        chk("rst_resp_valid", 32'(io_ifetch_resp_valid | io_lsu_resp_valid), 32'd0);
        chk("rst_resp_data", io_ifetch_resp_data | io_lsu_resp_data, 32'h0);

        // Both requesters permanently valid: grants must alternate, ifetch first.
        tick();
        reset = 1'b0;
        f_valid = 1'b1; f_addr = 32'h2000;
        l_valid = 1'b1; l_write = 1'b0; l_size = 2'd0; l_addr = 32'h2100;
        k = 0;
        while (grant_log.size() < 4 && k < 200) begin
            tick();
            k++;
        end
        f_valid = 1'b0; l_valid = 1'b0;
        chk("t3_grant_count", 32'(grant_log.size() >= 4 ? 4 : grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t3_order", 32'(grant_log[i]), 32'(i % 2));
        drain();

        // Fetch from 0x100: four read addresses, response at T+6.
        tick();
        f_valid = 1'b1; f_addr = 32'h100;
        @(negedge clock);
        chk("t1_accept", 32'(io_ifetch_req_ready), 32'd1);
        tick();
        f_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t1_addr", io_mem_a, 32'h100 + 32'(i));
            chk("t1_wr", 32'(io_mem_wr), 32'd0);
            tick();
        end
        @(negedge clock);
        chk("t1_early_resp", 32'(io_ifetch_resp_valid), 32'd0);
        tick();
        @(negedge clock);
        chk("t1_resp", 32'(io_ifetch_resp_valid), 32'd1);
        chk("t1_data", io_ifetch_resp_data, 32'h0010_0513);
        tick();

        // 4-byte store to 0x200: bytes go out little-endian, ack at T+5 with data 0.
        wd = 32'hAABB_CCDD;
        l_valid = 1'b1; l_write = 1'b1; l_size = 2'd2; l_addr = 32'h200; l_wdata = wd;
        @(negedge clock);
        chk("t2_accept", 32'(io_lsu_req_ready), 32'd1);
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t2_addr", io_mem_a, 32'h200 + 32'(i));
            chk("t2_wr", 32'(io_mem_wr), 32'd1);
            chk("t2_dout", 32'(io_mem_dout), 32'(wd[8*i +: 8]));
            tick();
        end
        @(negedge clock);
        chk("t2_resp", 32'(io_lsu_resp_valid), 32'd1);
        chk("t2_data", io_lsu_resp_data, 32'h0);
        tick();

        // 1-byte IO store held off by a full buffer for three cycles.
        buf_full = 1'b1;
        l_valid = 1'b1; l_write = 1'b1; l_size = 2'd0; l_addr = 32'h0003_0000; l_wdata = 32'h0000_005A;
        @(negedge clock);
        chk("t4_accept", 32'(io_lsu_req_ready), 32'd1);
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t4_held", 32'(io_mem_wr), 32'd0);
            chk("t4_no_ack", 32'(io_lsu_resp_valid), 32'd0);
            tick();
        end
        buf_full = 1'b0;
        @(negedge clock);
        chk("t4_write", 32'(io_mem_wr), 32'd1);
        chk("t4_addr", io_mem_a, 32'h0003_0000);
        chk("t4_dout", 32'(io_mem_dout), 32'h5A);
        tick();
        @(negedge clock);
        chk("t4_ack", 32'(io_lsu_resp_valid), 32'd1);
        tick();

        // Fetch wrapping past the top of the address space, with a 2-cycle stall.
        exp5 = model_read(32'hFFFF_FFFE, 4);
        f_valid = 1'b1; f_addr = 32'hFFFF_FFFE;
        @(negedge clock);
        chk("t5_accept", 32'(io_ifetch_req_ready), 32'd1);
        tick();
        f_valid = 1'b0;
        @(negedge clock);
        chk("t5_addr0", io_mem_a, 32'hFFFF_FFFE);
        tick();
        @(negedge clock);
        chk("t5_addr1", io_mem_a, 32'hFFFF_FFFF);
        tick();
        ready = 1'b0;
        @(negedge clock);
        chk("t5_addr_hold", io_mem_a, 32'hFFFF_FFFF);
        tick();
        tick();
        ready = 1'b1;
        @(negedge clock);
        chk("t5_addr2", io_mem_a, 32'h0000_0000);
        tick();
        @(negedge clock);
        chk("t5_addr3", io_mem_a, 32'h0000_0001);
        tick();
        @(negedge clock);
        chk("t5_early_resp", 32'(io_ifetch_resp_valid), 32'd0);
        tick();
        @(negedge clock);
        chk("t5_resp", 32'(io_ifetch_resp_valid), 32'd1);
        chk("t5_data", io_ifetch_resp_data, exp5);
        tick();

        // Reset in the middle of a 4-byte store, then a normal fetch.
        l_valid = 1'b1; l_write = 1'b1; l_size = 2'd2; l_addr = 32'h400; l_wdata = 32'h1122_3344;
        @(negedge clock);
        chk("t6_accept", 32'(io_lsu_req_ready), 32'd1);
        tick();
        l_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_wr", 32'(io_mem_wr), 32'd0);
        chk("t6_busy", 32'(io_busy), 32'd0);
        chk("t6_no_resp", 32'(io_lsu_resp_valid), 32'd0);
        tick();
        f_valid = 1'b1; f_addr = 32'h100;
        @(negedge clock);
        chk("t6_fetch_accept", 32'(io_ifetch_req_ready), 32'd1);
        wait_resp(1'b0, lat);
        chk("t6_fetch_latency", 32'(lat), 32'd6);
        chk("t6_fetch_data", io_ifetch_resp_data, 32'h0010_0513);

        // Randomized traffic with random stalls and IO backpressure.
        fork
            begin
                fork
                    rand_fetch(40);
                    rand_lsu(60);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    ready    = ($urandom_range(0, 3) != 0);
                    buf_full = ($urandom_range(0, 2) == 0);
                end
                ready = 1'b1;
                buf_full = 1'b0;
            end
        join
        drain();
        repeat (3) tick();

        foreach (shadow_mem[a]) chk("final_mem", 32'(bus_rd(a)), 32'(shadow_mem[a]));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
